game_timer_ctrl: RTL and testbench
==================================

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 SHALL have parameter DROP_BASE, default 8: drop period in game ticks at level 0.
REQ-002 SHALL have parameter MATCH_TIMEOUT, default 30: game ticks before a pending match times out.
REQ-003 SHALL have parameter LINES_PER_LEVEL, default 4: cleared lines per level increment.
REQ-004 SHALL have ports as follows:
- global_clk  in  1  sole clock, all logic on rising edge.
- rst_in  in  1  reset; synchronous, active-high.
- game_clk  in  1  slow game tick source, asynchronous to global_clk.
- stat_in  in  3  status code: 000 NORMAL, 001 MATCH_ING, 010 MATCH_CANCEL, 011 MATCH_SUCCESS, 100 GAME_INITIAL, 101 GAME_CNTDOWN, 110 GAME_ING, 111 GAME_OVER.
- lines_in  in  1  one-cycle pulse per cleared line.
- cntdown_out  out  2  countdown value, 3..0.
- cntdown_done_out  out  1  one-cycle pulse when countdown reaches 0.
- drop_out  out  1  one-cycle gravity-drop pulse.
- level_out  out  3  speed level, 0..7.
- match_timeout_out  out  1  one-cycle pulse on match timeout.

Function
REQ-005 SHALL pass game_clk through a 2-flop synchronizer plus edge detector, producing internal tick (1 cycle high) on each synchronized rising edge; tick SHALL be high on the 3rd global_clk edge after game_clk rises.
REQ-006 SHALL implement states IDLE, MATCH_WAIT, CNTDOWN, RUN, HALT, selected from registered stat_in: 001->MATCH_WAIT; 100->INIT (transient load, treated as IDLE); 101->CNTDOWN; 110->RUN; 111->HALT; 000/010/011->IDLE.
REQ-007 SHALL clear the counter belonging to a state on every entry into that state (stat_in change counts as entry, even mid-count).
REQ-008 MATCH_WAIT: tick counter SHALL increment per tick; when it reaches MATCH_TIMEOUT, match_timeout_out SHALL pulse once and the counter SHALL saturate; no further pulse until re-entry.
REQ-009 stat_in=100: cntdown_out SHALL load 3; level and line count SHALL clear to 0.
REQ-010 CNTDOWN: each tick decrements cntdown_out; on the 1->0 transition cntdown_done_out SHALL pulse in the same cycle cntdown_out becomes 0; at 0 it SHALL saturate without further pulses.
REQ-011 RUN: period = DROP_BASE - level_out, clamped to minimum 1; drop counter increments per tick; on the tick where counter equals period-1, drop_out SHALL pulse and counter SHALL return to 0.
REQ-012 RUN: each lines_in pulse increments line count (modulo LINES_PER_LEVEL); on wrap level_out SHALL increment, saturating at 7.
REQ-013 lines_in and tick in the same cycle SHALL both be processed; the new level SHALL apply to the next period comparison only.
REQ-014 lines_in outside RUN SHALL be ignored.
REQ-015 HALT: drop_out SHALL stay 0; level_out and cntdown_out held.
REQ-016 IDLE: drop_out, cntdown_done_out, match_timeout_out SHALL be 0; level_out SHALL hold until stat_in=100 or reset.
REQ-017 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-018 While rst_in=1 at a clock edge: state IDLE, cntdown_out=3, level_out=0, drop_out=0, cntdown_done_out=0, match_timeout_out=0, all counters and synchronizer flops 0.
REQ-019 Reset SHALL override every other input, including mid-countdown and mid-drop-period.

Verification
REQ-020 stat_in=100 then 101, 3 game_clk pulses -> cntdown_out 3,2,1,0; one cntdown_done_out pulse coincident with 0; 4th pulse -> no change.
REQ-021 stat_in=110, level 0, 16 ticks -> drop_out pulses on ticks 8 and 16 exactly.
REQ-022 RUN, 4 lines_in pulses, 4th coincident with a tick -> level_out=1 on next cycle; subsequent drop period 7 ticks.
REQ-023 RUN, 40 lines_in pulses -> level_out saturates at 7; drop period 1 tick (drop_out on every tick).
REQ-024 stat_in=001, 30 ticks -> single match_timeout_out on tick 30; stat_in 001->000->001 then 29 ticks -> no pulse.
REQ-025 rst_in asserted during CNTDOWN at cntdown_out=1 -> next cycle cntdown_out=3, no cntdown_done_out pulse; game_clk edge at reset release produces no tick.

Source files
------------

// File: rtl/game_timer_ctrl.sv
// game_timer_ctrl: game-tick driven timing for a falling-block game.
// Synchronizes the slow game_clk into global_clk, then derives the match
// timeout, pre-game countdown, gravity drop pulses and speed level from the
// registered status code.
module game_timer_ctrl #(
  parameter int DROP_BASE       = 8,
  parameter int MATCH_TIMEOUT   = 30,
  parameter int LINES_PER_LEVEL = 4
) (
  input  logic       global_clk,
  input  logic       rst_in,
  input  logic       game_clk,
  input  logic [2:0] stat_in,
  input  logic       lines_in,
  output logic [1:0] cntdown_out,
  output logic       cntdown_done_out,
  output logic       drop_out,
  output logic [2:0] level_out,
  output logic       match_timeout_out
);

  // Counter widths: drop counter holds 0..DROP_BASE-1, match counter 0..MATCH_TIMEOUT.
  localparam int DCW = (DROP_BASE > 1) ? $clog2(DROP_BASE) : 1;
  localparam int MCW = (MATCH_TIMEOUT > 0) ? $clog2(MATCH_TIMEOUT + 1) : 1;
  localparam int LCW = (LINES_PER_LEVEL > 1) ? $clog2(LINES_PER_LEVEL) : 1;

  // Status codes as presented on stat_in.
  localparam logic [2:0] STAT_NORMAL        = 3'b000;
  localparam logic [2:0] STAT_MATCH_ING     = 3'b001;
  localparam logic [2:0] STAT_MATCH_CANCEL  = 3'b010;
  localparam logic [2:0] STAT_MATCH_SUCCESS = 3'b011;
  localparam logic [2:0] STAT_GAME_INITIAL  = 3'b100;
  localparam logic [2:0] STAT_GAME_CNTDOWN  = 3'b101;
  localparam logic [2:0] STAT_GAME_ING      = 3'b110;
  localparam logic [2:0] STAT_GAME_OVER     = 3'b111;

  // Controller states decoded from the registered status.
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_MATCH_WAIT = 3'd1;
  localparam logic [2:0] ST_CNTDOWN    = 3'd2;
  localparam logic [2:0] ST_RUN        = 3'd3;
  localparam logic [2:0] ST_HALT       = 3'd4;

  // Synchronizer, edge detector and post-reset arming.
  logic           r_sync1;
  logic           r_sync2;
  logic           r_sync3;
  logic [1:0]     r_sync_valid;
  logic           r_armed;
  logic           w_tick;

  // Registered status and entry detection.
  logic [2:0]     r_stat_q;
  logic [2:0]     r_stat_prev;
  logic [2:0]     w_state;
  logic           w_init;
  logic           w_entry;

  // Per-state counters and outputs.
  logic [MCW-1:0] r_match_cnt;
  logic [MCW-1:0] w_match_nxt;
  logic [DCW-1:0] r_drop_cnt;
  logic [DCW-1:0] w_period_m1;
  logic [LCW-1:0] r_line_cnt;
  logic [1:0]     r_cntdown;
  logic [2:0]     r_level;
  logic           r_drop;
  logic           r_done;
  logic           r_timeout;

  // Bring game_clk into the global_clk domain and track the sampled level.
  // A rising edge only counts once a low level has been seen after reset, so
  // a game_clk already high (or rising) at reset release never makes a tick.
  always_ff @(posedge global_clk) begin
    if (rst_in) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync3      <= 1'b0;
      r_sync_valid <= 2'b00;
      r_armed      <= 1'b0;
    end else begin
      r_sync1      <= game_clk;
      r_sync2      <= r_sync1;
      r_sync3      <= r_sync2;
      r_sync_valid <= {r_sync_valid[0], 1'b1};
      r_armed      <= r_armed | (r_sync_valid[1] & ~r_sync2);
    end
  end

  assign w_tick = r_sync2 & ~r_sync3 & r_armed;

  // Register the status code and keep its previous value for entry detection.
  always_ff @(posedge global_clk) begin
    if (rst_in) begin
      r_stat_q    <= STAT_NORMAL;
      r_stat_prev <= STAT_NORMAL;
    end else begin
      r_stat_q    <= stat_in;
      r_stat_prev <= r_stat_q;
    end
  end

  // Decode the registered status into a controller state; INIT is an IDLE
  // flavour that additionally loads the game counters.
  always_comb begin
    w_state = ST_IDLE;
    w_init  = 1'b0;
    case (r_stat_q)
      STAT_MATCH_ING:     w_state = ST_MATCH_WAIT;
      STAT_GAME_INITIAL:  begin
        w_state = ST_IDLE;
        w_init  = 1'b1;
      end
      STAT_GAME_CNTDOWN:  w_state = ST_CNTDOWN;
      STAT_GAME_ING:      w_state = ST_RUN;
      STAT_GAME_OVER:     w_state = ST_HALT;
      STAT_NORMAL,
      STAT_MATCH_CANCEL,
      STAT_MATCH_SUCCESS: w_state = ST_IDLE;
      default:            w_state = ST_IDLE;
    endcase
  end

  assign w_entry     = (r_stat_q != r_stat_prev);
  assign w_match_nxt = r_match_cnt + MCW'(1'b1);

  // Drop period minus one, from the current level, clamped to a 1-tick period.
  always_comb begin
    if (int'(r_level) >= DROP_BASE - 1) begin
      w_period_m1 = {DCW{1'b0}};
    end else begin
      w_period_m1 = DCW'(DROP_BASE - 1 - int'(r_level));
    end
  end

  // Per-state counters, level tracking and one-cycle output pulses.
  always_ff @(posedge global_clk) begin
    if (rst_in) begin
      r_match_cnt <= {MCW{1'b0}};
      r_drop_cnt  <= {DCW{1'b0}};
      r_line_cnt  <= {LCW{1'b0}};
      r_cntdown   <= 2'd3;
      r_level     <= 3'd0;
      r_drop      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_drop    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      case (w_state)
        ST_MATCH_WAIT: begin
          if (w_entry) begin
            r_match_cnt <= {MCW{1'b0}};
          end else if (w_tick && (r_match_cnt != MCW'(MATCH_TIMEOUT))) begin
            r_match_cnt <= w_match_nxt;
            if (w_match_nxt == MCW'(MATCH_TIMEOUT)) begin
              r_timeout <= 1'b1;
            end
          end
        end
        ST_CNTDOWN: begin
          if (w_entry) begin
            r_cntdown <= 2'd3;
          end else if (w_tick && (r_cntdown != 2'd0)) begin
            r_cntdown <= r_cntdown - 2'd1;
            if (r_cntdown == 2'd1) begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // ">=" rather than "==" so a level-up that shortens the period
          // below the running count still fires on the next tick.
          if (w_entry) begin
            r_drop_cnt <= {DCW{1'b0}};
          end else if (w_tick) begin
            if (r_drop_cnt >= w_period_m1) begin
              r_drop     <= 1'b1;
              r_drop_cnt <= {DCW{1'b0}};
            end else begin
              r_drop_cnt <= r_drop_cnt + DCW'(1'b1);
            end
          end
          if (lines_in) begin
            if (r_line_cnt == LCW'(LINES_PER_LEVEL - 1)) begin
              r_line_cnt <= {LCW{1'b0}};
              if (r_level != 3'd7) begin
                r_level <= r_level + 3'd1;
              end
            end else begin
              r_line_cnt <= r_line_cnt + LCW'(1'b1);
            end
          end
        end
        ST_HALT: begin
          r_drop <= 1'b0;
        end
        default: begin
          if (w_init) begin
            r_cntdown  <= 2'd3;
            r_level    <= 3'd0;
            r_line_cnt <= {LCW{1'b0}};
          end
        end
      endcase
    end
  end

  assign cntdown_out       = r_cntdown;
  assign cntdown_done_out  = r_done;
  assign drop_out          = r_drop;
  assign level_out         = r_level;
  assign match_timeout_out = r_timeout;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb_game_timer_ctrl: directed bench for game_timer_ctrl. Expected pulse
// tick numbers are queued when ticks are driven and popped when the DUT
// pulses; levels are checked directly after each step.
module tb_game_timer_ctrl;

  logic       global_clk = 1'b0;
  logic       rst_in     = 1'b1;
  logic       game_clk   = 1'b0;
  logic [2:0] stat_in    = 3'b000;
  logic       lines_in   = 1'b0;
  logic [1:0] cntdown_out;
  logic       cntdown_done_out;
  logic       drop_out;
  logic [2:0] level_out;
  logic       match_timeout_out;

  int n_cmp  = 0;
  int n_err  = 0;
  int tick_no = 0;
  int base;
  int q_drop[$];
  int q_done[$];
  int q_to[$];

  game_timer_ctrl #(
    .DROP_BASE(8),
    .MATCH_TIMEOUT(30),
    .LINES_PER_LEVEL(4)
  ) dut (
    .global_clk(global_clk),
    .rst_in(rst_in),
    .game_clk(game_clk),
    .stat_in(stat_in),
    .lines_in(lines_in),
    .cntdown_out(cntdown_out),
    .cntdown_done_out(cntdown_done_out),
    .drop_out(drop_out),
    .level_out(level_out),
    .match_timeout_out(match_timeout_out)
  );

  always #5 global_clk = ~global_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One game_clk pulse; optional lines_in pulse lands in the same cycle as the tick.
  task automatic game_tick(input logic with_line);
    tick_no++;
    @(negedge global_clk); game_clk = 1'b1;
    @(posedge global_clk);
    @(posedge global_clk);
    @(negedge global_clk); lines_in = with_line;
    @(negedge global_clk); lines_in = 1'b0;
    repeat (2) @(negedge global_clk);
    game_clk = 1'b0;
    repeat (4) @(negedge global_clk);
  endtask

  task automatic line_pulse();
    @(negedge global_clk); lines_in = 1'b1;
    @(negedge global_clk); lines_in = 1'b0;
  endtask

  task automatic set_stat(input logic [2:0] v);
    @(negedge global_clk); stat_in = v;
    repeat (3) @(negedge global_clk);
  endtask

  // Scoreboard: every output pulse must match the next queued tick number.
  always @(negedge global_clk) begin
    int exp_t;
    if (drop_out === 1'b1) begin
      if (q_drop.size() > 0) exp_t = q_drop.pop_front(); else exp_t = -1;
      n_cmp++;
      assert (tick_no === exp_t) else begin
        n_err++;
        $error("FAIL drop_tick observed=%0d expected=%0d", tick_no, exp_t);
      end
    end
    if (cntdown_done_out === 1'b1) begin
      if (q_done.size() > 0) exp_t = q_done.pop_front(); else exp_t = -1;
      n_cmp++;
      assert ((tick_no === exp_t) && (cntdown_out === 2'd0)) else begin
        n_err++;
        $error("FAIL done_tick observed=%0d/cnt=%0d expected=%0d/cnt=0", tick_no, cntdown_out, exp_t);
      end
    end
    if (match_timeout_out === 1'b1) begin
      if (q_to.size() > 0) exp_t = q_to.pop_front(); else exp_t = -1;
      n_cmp++;
      assert (tick_no === exp_t) else begin
        n_err++;
        $error("FAIL timeout_tick observed=%0d expected=%0d", tick_no, exp_t);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge global_clk);
    chk("rst_cntdown", 32'(cntdown_out), 32'd3);
    chk("rst_level", 32'(level_out), 32'd0);
    chk("rst_drop", 32'(drop_out), 32'd0);
    chk("rst_done", 32'(cntdown_done_out), 32'd0);
    chk("rst_timeout", 32'(match_timeout_out), 32'd0);
    rst_in = 1'b0;
    repeat (4) @(negedge global_clk);

    // Countdown 3,2,1,0 with one done pulse, then saturation
    set_stat(3'b100);
    chk("init_cntdown", 32'(cntdown_out), 32'd3);
    chk("init_level", 32'(level_out), 32'd0);
    set_stat(3'b101);
    base = tick_no;
    q_done.push_back(base + 3);
    game_tick(1'b0); chk("cd_after1", 32'(cntdown_out), 32'd2);
    game_tick(1'b0); chk("cd_after2", 32'(cntdown_out), 32'd1);
    game_tick(1'b0); chk("cd_after3", 32'(cntdown_out), 32'd0);
    game_tick(1'b0); chk("cd_after4", 32'(cntdown_out), 32'd0);
    chk("done_q_empty", 32'(q_done.size()), 32'd0);

    // RUN at level 0: drops on ticks 8 and 16
    set_stat(3'b100);
    set_stat(3'b110);
    base = tick_no;
    q_drop.push_back(base + 8);
    q_drop.push_back(base + 16);
    for (int i = 0; i < 16; i++) game_tick(1'b0);
    chk("drop_q_empty_l0", 32'(q_drop.size()), 32'd0);
    chk("level_l0", 32'(level_out), 32'd0);

    // HALT: lines ignored, no drops, outputs held
    set_stat(3'b111);
    for (int i = 0; i < 4; i++) line_pulse();
    game_tick(1'b0);
    game_tick(1'b0);
    chk("halt_level", 32'(level_out), 32'd0);
    chk("halt_cntdown", 32'(cntdown_out), 32'd3);

    // RUN: 4th line with a tick -> level 1, then 7-tick period
    set_stat(3'b100);
    set_stat(3'b110);
    for (int i = 0; i < 3; i++) line_pulse();
    chk("level_3lines", 32'(level_out), 32'd0);
    base = tick_no;
    q_drop.push_back(base + 7);
    q_drop.push_back(base + 14);
    game_tick(1'b1);
    chk("level_up1", 32'(level_out), 32'd1);
    for (int i = 0; i < 13; i++) game_tick(1'b0);
    chk("drop_q_empty_l1", 32'(q_drop.size()), 32'd0);

    // RUN: 40 lines saturate level at 7, drop every tick
    set_stat(3'b100);
    chk("level_cleared", 32'(level_out), 32'd0);
    set_stat(3'b110);
    for (int i = 0; i < 40; i++) line_pulse();
    chk("level_sat", 32'(level_out), 32'd7);
    base = tick_no;
    for (int i = 1; i <= 3; i++) q_drop.push_back(base + i);
    for (int i = 0; i < 3; i++) game_tick(1'b0);
    chk("drop_q_empty_l7", 32'(q_drop.size()), 32'd0);

    // Match timeout: one pulse on tick 30, saturation, re-entry restarts
    set_stat(3'b001);
    base = tick_no;
    q_to.push_back(base + 30);
    for (int i = 0; i < 32; i++) game_tick(1'b0);
    chk("to_q_empty1", 32'(q_to.size()), 32'd0);
    set_stat(3'b000);
    set_stat(3'b001);
    for (int i = 0; i < 29; i++) game_tick(1'b0);
    base = tick_no;
    q_to.push_back(base + 1);
    game_tick(1'b0);
    chk("to_q_empty2", 32'(q_to.size()), 32'd0);

    // Reset mid-countdown; game_clk rising at release yields no tick
    set_stat(3'b100);
    set_stat(3'b101);
    game_tick(1'b0);
    game_tick(1'b0);
    chk("cd_before_rst", 32'(cntdown_out), 32'd1);
    @(negedge global_clk); rst_in = 1'b1;
    @(negedge global_clk);
    chk("rst_mid_cntdown", 32'(cntdown_out), 32'd3);
    chk("rst_mid_done", 32'(cntdown_done_out), 32'd0);
    repeat (2) @(negedge global_clk);
    rst_in   = 1'b0;
    game_clk = 1'b1;
    repeat (8) @(negedge global_clk);
    chk("no_tick_at_release", 32'(cntdown_out), 32'd3);
    game_clk = 1'b0;
    repeat (4) @(negedge global_clk);
    game_tick(1'b0);
    chk("tick_after_release", 32'(cntdown_out), 32'd2);
    chk("done_q_final", 32'(q_done.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
